// File: rtl/lbist_seq_pkg.sv
// lbist_seq_pkg: shared state and status encodings for the LBIST sequencer.
package lbist_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_TEST,
        S_BIST_RUN,
        S_BIST_EVAL,
        S_RST_FUNC,
        S_FUNC_RUN,
        S_DONE
    } lbist_state_e;

    typedef enum logic [2:0] {
        ST_NONE         = 3'd0,
        ST_PASS         = 3'd1,
        ST_BIST_FAIL    = 3'd2,
        ST_BIST_TIMEOUT = 3'd3,
        ST_EXIT_FAIL    = 3'd4,
        ST_FUNC_TIMEOUT = 3'd5
    } lbist_status_e;

endpackage

// File: rtl/lbist_phase_cnt.sv
// lbist_phase_cnt: phase cycle counter with synchronous clear and terminal-count compare.
module lbist_phase_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt <= '0;
        else if (clr_i)
            cnt <= '0;
        else if (en_i)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc_o = cnt == tc_val_i;

endmodule

// File: rtl/lbist_sequencer.sv
// lbist_sequencer: drives the RI5CY LBIST wrapper through reset, BIST, verdict and
// optional functional boot, exposing a sticky pass flag, status code and exit value.
module lbist_sequencer
    import lbist_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int BIST_TIMEOUT = 200000,
    parameter int FUNC_TIMEOUT = 1000000,
    parameter int CNT_W        = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        run_func_i,
    input  logic        test_over_i,
    input  logic        go_nogo_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        core_rst_no,
    output logic        test_mode_o,
    output logic        test_mode_tp_o,
    output logic        normal_test_o,
    output logic        clock_en_o,
    output logic        fetch_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [2:0]  status_o,
    output logic [31:0] exit_value_o
);

    localparam longint MAX_P = longint'(RESET_CYCLES > BIST_TIMEOUT ?
        (RESET_CYCLES > FUNC_TIMEOUT ? RESET_CYCLES : FUNC_TIMEOUT) :
        (BIST_TIMEOUT > FUNC_TIMEOUT ? BIST_TIMEOUT : FUNC_TIMEOUT));

    if (RESET_CYCLES < 1 || BIST_TIMEOUT < 1 || FUNC_TIMEOUT < 1 ||
        (CNT_W < 63 && ((MAX_P - 1) >> CNT_W) != 0)) begin : g_param_chk
        $error("lbist_sequencer: phase lengths must be >=1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIST_TC = CNT_W'(BIST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FUNC_TC = CNT_W'(FUNC_TIMEOUT - 1);

    lbist_state_e  state, state_d;
    lbist_status_e status, status_d;
    logic          pass_d, run_func, run_func_d, tc;
    logic [31:0]   exit_d;

    lbist_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_d != state),
        .en_i     (!(state inside {S_IDLE, S_DONE})),
        .tc_val_i (state inside {S_RST_TEST, S_RST_FUNC} ? RST_TC :
                   state == S_BIST_RUN ? BIST_TC : FUNC_TC),
        .tc_o     (tc)
    );

    always_comb begin
        state_d    = state;
        status_d   = status;
        pass_d     = pass_o;
        exit_d     = exit_value_o;
        run_func_d = run_func;
        case (state)
            S_IDLE, S_DONE: if (start_i) begin
                state_d    = S_RST_TEST;
                run_func_d = run_func_i;
                status_d   = ST_NONE;
                pass_d     = 1'b0;
                exit_d     = '0;
            end
            S_RST_TEST: if (tc) state_d = S_BIST_RUN;
            S_BIST_RUN: if (test_over_i) begin
                state_d = S_BIST_EVAL;
            end else if (tc) begin
                state_d  = S_DONE;
                status_d = ST_BIST_TIMEOUT;
            end
            S_BIST_EVAL: begin
                state_d  = go_nogo_i && run_func ? S_RST_FUNC : S_DONE;
                status_d = !go_nogo_i ? ST_BIST_FAIL : run_func ? ST_NONE : ST_PASS;
                pass_d   = go_nogo_i && !run_func;
            end
            S_RST_FUNC: if (tc) state_d = S_FUNC_RUN;
            S_FUNC_RUN: if (exit_valid_i) begin
                state_d  = S_DONE;
                exit_d   = exit_value_i;
                status_d = exit_value_i == '0 ? ST_PASS : ST_EXIT_FAIL;
                pass_d   = exit_value_i == '0;
            end else if (tc) begin
                state_d  = S_DONE;
                status_d = ST_FUNC_TIMEOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controls are decoded from the next state so each one changes on the first cycle of its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            status         <= ST_NONE;
            pass_o         <= 1'b0;
            exit_value_o   <= '0;
            run_func       <= 1'b0;
            core_rst_no    <= 1'b0;
            test_mode_o    <= 1'b0;
            test_mode_tp_o <= 1'b0;
            normal_test_o  <= 1'b0;
            clock_en_o     <= 1'b0;
            fetch_enable_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state          <= state_d;
            status         <= status_d;
            pass_o         <= pass_d;
            exit_value_o   <= exit_d;
            run_func       <= run_func_d;
            core_rst_no    <= state_d inside {S_BIST_RUN, S_BIST_EVAL, S_FUNC_RUN};
            test_mode_o    <= state_d inside {S_RST_TEST, S_BIST_RUN, S_BIST_EVAL};
            test_mode_tp_o <= state_d inside {S_RST_TEST, S_BIST_RUN, S_BIST_EVAL};
            normal_test_o  <= state_d inside {S_RST_FUNC, S_FUNC_RUN};
            clock_en_o     <= state_d != S_IDLE;
            fetch_enable_o <= state_d == S_FUNC_RUN;
            busy_o         <= !(state_d inside {S_IDLE, S_DONE});
            done_o         <= state_d == S_DONE;
        end
    end

    assign status_o = status;

endmodule

// File: tb/tb_lbist_sequencer.sv
// tb_lbist_sequencer: randomized sequences against a phase-length/verdict reference model.
module tb_lbist_sequencer;

    localparam int RC = 4;
    localparam int BT = 50;
    localparam int FT = 60;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0, run_func_i = 1'b0, test_over_i = 1'b0, go_nogo_i = 1'b0;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = '0;
    logic        core_rst_no, test_mode_o, test_mode_tp_o, normal_test_o, clock_en_o;
    logic        fetch_enable_o, busy_o, done_o, pass_o;
    logic [2:0]  status_o;
    logic [31:0] exit_value_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    lbist_sequencer #(
        .RESET_CYCLES (RC),
        .BIST_TIMEOUT (BT),
        .FUNC_TIMEOUT (FT),
        .CNT_W        (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .run_func_i     (run_func_i),
        .test_over_i    (test_over_i),
        .go_nogo_i      (go_nogo_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .core_rst_no    (core_rst_no),
        .test_mode_o    (test_mode_o),
        .test_mode_tp_o (test_mode_tp_o),
        .normal_test_o  (normal_test_o),
        .clock_en_o     (clock_en_o),
        .fetch_enable_o (fetch_enable_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .status_o       (status_o),
        .exit_value_o   (exit_value_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {19'd0, core_rst_no, test_mode_o, test_mode_tp_o, normal_test_o, clock_en_o,
                fetch_enable_o, busy_o, done_o, pass_o, status_o};
    endfunction

    // k: BIST_RUN cycle index where test_over rises; e: FUNC_RUN cycle index of exit_valid.
    task automatic run_seq(input bit rf, input bit go, input int k, input int e,
                           input logic [31:0] xv, input bit poke);
        int  busy_n, rst_low, bist_i, func_i, bad, exp_busy;
        bit  fe_seen, ok, eval, func, fexit;
        logic [2:0]  exp_st;
        logic [31:0] exp_val;
        eval    = k <= BT - 1;
        func    = eval && go && rf;
        fexit   = func && e <= FT - 1;
        exp_busy = RC + (eval ? k + 2 : BT) + (func ? RC + (fexit ? e + 1 : FT) : 0);
        exp_st  = !eval ? 3'd3 : !go ? 3'd2 : !rf ? 3'd1 : !fexit ? 3'd5 : xv == 0 ? 3'd1 : 3'd4;
        exp_val = fexit ? xv : 32'd0;
        busy_n = 0; rst_low = 0; bist_i = 0; func_i = 0; bad = 0; fe_seen = 0; ok = 0;
        @(negedge clk_i);
        start_i = 1'b1; run_func_i = rf; go_nogo_i = go;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            run_func_i = 1'($urandom);
            if (done_o) begin
                ok = 1;
                break;
            end
            busy_n  += int'(busy_o);
            rst_low += int'(!core_rst_no);
            fe_seen |= fetch_enable_o;
            test_over_i  = 1'b0;
            exit_valid_i = 1'b0;
            exit_value_i = $urandom;
            if (core_rst_no && test_mode_o) begin
                if (!test_mode_tp_o || normal_test_o || !clock_en_o) bad++;
                test_over_i = bist_i >= k;
                if (poke && bist_i == 2) start_i = 1'b1;
                bist_i++;
            end
            if (core_rst_no && fetch_enable_o) begin
                if (!normal_test_o || test_mode_o) bad++;
                exit_valid_i = func_i == e;
                if (exit_valid_i) exit_value_i = xv;
                func_i++;
            end
        end
        test_over_i = 1'b0; exit_valid_i = 1'b0;
        chk("done_reached", 32'(ok), 1);
        chk("status", 32'(status_o), 32'(exp_st));
        chk("pass", 32'(pass_o), 32'(exp_st == 3'd1));
        chk("exit_value", exit_value_o, exp_val);
        chk("busy_cycles", busy_n, exp_busy);
        chk("rst_low_cycles", rst_low, func ? 2 * RC : RC);
        chk("fetch_seen", 32'(fe_seen), 32'(func));
        chk("run_ctrls", bad, 0);
        chk("done_ctrls", {core_rst_no, test_mode_o, test_mode_tp_o, normal_test_o,
                           fetch_enable_o, clock_en_o, busy_o}, 7'b0000010);
    endtask

    initial begin
        logic [31:0] xv;
        bit          seen;
        repeat (3) @(negedge clk_i);
        chk("reset_outs", out_vec(), 0);
        chk("reset_exit", exit_value_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_outs", out_vec(), 0);
        run_seq(0, 1, 15, 0, 0, 0);
        run_seq(0, 0, 15, 0, 0, 0);
        run_seq(0, 1, 1000, 0, 0, 0);
        run_seq(1, 1, 5, 7, 32'h0, 0);
        run_seq(1, 1, 5, 3, 32'h5, 0);
        run_seq(1, 0, 0, 3, 32'h5, 0);
        run_seq(0, 1, BT - 1, 0, 0, 0);
        run_seq(0, 1, BT, 0, 0, 0);
        run_seq(1, 1, 2, FT - 1, 32'h1234, 0);
        run_seq(1, 1, 2, FT, 32'h0, 0);
        run_seq(0, 1, 10, 0, 0, 1);
        run_seq(1, 1, 8, 4, 32'h0, 1);
        // Asynchronous reset in the middle of the functional phase.
        @(negedge clk_i);
        start_i = 1'b1; run_func_i = 1'b1; go_nogo_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            test_over_i = core_rst_no && test_mode_o;
            seen = fetch_enable_o;
        end
        chk("func_reached", 32'(seen), 1);
        test_over_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_outs", out_vec(), 0);
        chk("async_rst_exit", exit_value_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_seq(1, 1, 3, 6, 32'h0, 0);
        for (int i = 0; i < 14; i++) begin
            xv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_seq(1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, BT + 3),
                    $urandom_range(0, FT + 3), xv, 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
